mult_bcd_engine: RTL and testbench
==================================

Name: mult_bcd_engine

Overview:
- Parametrised signed multiply-and-convert engine.
- Accepts two signed two's-complement operands over a valid/ready handshake and multiplies them with a sequential radix-2 Booth datapath.
- Selects the product or one of the operands for display and converts its magnitude to NDIG BCD digits plus a sign flag, using sequential double-dabble.
- Sits between operand capture (keypad / BCD-to-binary) and the 7-segment driver. Replaces the fixed 8-bit multiplier, priority select and BCD conversion chain with one handshaked block.

Parameters:
- WIDTH, 8: operand width, signed, >= 2.
- NDIG, 5: BCD digits of magnitude output. Must satisfy 10^NDIG > 2^(2*WIDTH-2); checked at elaboration with $error.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and sel are valid.
- in_ready  out  1  engine can accept; equals (state==IDLE).
- op_a  in  WIDTH  signed multiplicand.
- op_b  in  WIDTH  signed multiplier.
- sel  in  2  display source: 00/11 product, 01 op_a, 10 op_b. Sampled at acceptance.
- out_valid  out  1  result registers valid.
- out_ready  in  1  consumer takes result.
- product  out  2*WIDTH  signed product op_a*op_b.
- digits  out  4*NDIG  BCD magnitude of the selected value; digit 0 is in bits [3:0].
- neg  out  1  selected value < 0.
- busy  out  1  state != IDLE.

Behaviour:
- Reset, asynchronous on rst low:
  - state=IDLE.
  - product, digits, neg, out_valid all 0; busy=0.
  - in_ready=1 (combinational from IDLE).
  - Internal operand, accumulator and counter registers cleared.
  - Reset mid-operation aborts the transaction with no output.
- Acceptance: on the rising edge where in_valid & in_ready = 1, latch op_a, op_b and sel, then go to MULT. Inputs are ignored in every other state.
- MULT, WIDTH cycles:
  - One Booth step per cycle, on accumulator {P[WIDTH:0] sign-extended, Q, q_-1}.
  - Pair 01 adds A; pair 10 subtracts A; then arithmetic right shift.
  - After WIDTH steps, product = full exact 2*WIDTH signed result. No truncation: (-2^(W-1))*(-2^(W-1)) = 2^(2W-2) fits.
- ABS, 1 cycle:
  - Selected value V is the product, or the chosen operand sign-extended to 2*WIDTH.
  - neg = V[MSB].
  - Magnitude M = neg ? -V : V, held as unsigned 2*WIDTH bits. Zero gives neg=0.
- CONV, 2*WIDTH cycles:
  - Each cycle, every BCD nibble >= 5 gets +3, then {bcd, M} shifts left by 1.
  - The product register is loaded at the end of MULT but is not exported until HOLD.
- HOLD:
  - out_valid=1. product, digits and neg are stable.
  - On out_valid & out_ready: out_valid goes 0 next edge and state returns to IDLE. Output data registers keep their last values.
  - If out_ready is already high when out_valid rises, the handshake completes in that single cycle.
- Latency: out_valid rises 3*WIDTH+1 edges after the acceptance edge (25 for WIDTH=8). Latency is independent of sel and operand values.
- Throughput: one result per 3*WIDTH+3 cycles minimum. There is no acceptance in the cycle HOLD exits; in_ready is high the cycle after.
- Leading zero digits are output as 0 (see optional feature).

Optional Feature:
- Macro: MULT_BCD_BLANK_EN.
- Defined: after CONV, each leading-zero digit above digit 0 is replaced by 4'hF (blank code for the segment driver), scanning from the MSD down to the first nonzero digit. Digit 0 is never blanked. This adds no latency; it is applied in the last CONV cycle.
- Undefined: all digits are the raw BCD values, including leading zeros.

Test Plan:
1. WIDTH=8; op_a=12, op_b=-11, sel=00 -> out_valid exactly 25 cycles after acceptance; product=16'hFF7C, neg=1, digits=20'h00132.
2. op_a=-128, op_b=-128, sel=00 -> product=16'h4000, neg=0, digits=20'h16384. Also 127*-128 -> product=16'hC080, digits=20'h16256, neg=1.
3. op_a=-7, op_b=3, sel=01 -> product=16'hFFEB, digits=20'h00007, neg=1. sel=10 with the same operands -> digits=20'h00003, neg=0.
4. Hold out_ready=0 for 10 cycles after out_valid, while toggling in_valid with new operands -> in_ready=0 and outputs are unchanged throughout. Release out_ready -> out_valid falls next edge, in_ready=1 one cycle later, and the new transaction runs correctly.
5. Assert rst low during MULT step 4 -> all outputs 0 immediately, asynchronously. Deassert and issue 5*5 -> digits=20'h00025, with no residue from the aborted operation.
6. MULT_BCD_BLANK_EN defined: 0*55 -> digits=20'hFFFF0, neg=0; -3*100 -> digits=20'hFF300, neg=1.

Source files
------------

// File: rtl/mult_bcd_engine.sv
// rtl/mult_bcd_engine.sv - handshaked signed Booth multiplier with double-dabble BCD conversion (optional MULT_BCD_BLANK_EN)
module mult_bcd_engine #(
    parameter int WIDTH = 8,
    parameter int NDIG  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    input  logic [1:0]           sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic [4*NDIG-1:0]    digits,
    output logic                 neg,
    output logic                 busy
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(PW + 1);

    function automatic int dec_digits(input int bits);
        logic [127:0] v;
        int           n;
        v = 128'd1 << bits;
        n = 0;
        while (v != 128'd0) begin
            v = v / 128'd10;
            n++;
        end
        return n;
    endfunction

    if (NDIG < dec_digits(2 * WIDTH - 2)) begin : g_ndig_check
        $error("NDIG too small for WIDTH");
    end

    typedef enum logic [2:0] {IDLE, MULT, ABS, CONV, HOLD} state_t;
    state_t state, state_nxt;

    logic [WIDTH-1:0]  a_r, b_r;
    logic [1:0]        sel_r;
    logic [WIDTH:0]    acc_p;
    logic [WIDTH-1:0]  acc_q;
    logic              acc_qm1;
    logic [PW-1:0]     prod_r, mag_r;
    logic              neg_r;
    logic [4*NDIG-1:0] bcd_r;
    logic [CW-1:0]     cnt;

    logic [WIDTH:0]    a_ext, p_sum, p_nxt;
    logic [WIDTH-1:0]  q_nxt;
    logic [PW-1:0]     sel_val, sel_mag;
    logic              sel_neg;
    logic [4*NDIG-1:0] bcd_adj, bcd_shift, digits_fmt;
    logic              mult_last, conv_last;

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign mult_last = (cnt == CW'(WIDTH - 1));
    assign conv_last = (cnt == CW'(PW - 1));

    // Booth step: P carries one guard bit so -2^(W-1) can be subtracted without overflow
    assign a_ext = {a_r[WIDTH-1], a_r};
    always_comb begin
        case ({acc_q[0], acc_qm1})
            2'b01:   p_sum = acc_p + a_ext;
            2'b10:   p_sum = acc_p - a_ext;
            default: p_sum = acc_p;
        endcase
        p_nxt = {p_sum[WIDTH], p_sum[WIDTH:1]};
        q_nxt = {p_sum[0], acc_q[WIDTH-1:1]};
    end

    always_comb begin
        case (sel_r)
            2'b01:   sel_val = {{WIDTH{a_r[WIDTH-1]}}, a_r};
            2'b10:   sel_val = {{WIDTH{b_r[WIDTH-1]}}, b_r};
            default: sel_val = prod_r;
        endcase
        sel_neg = sel_val[PW-1];
        sel_mag = sel_neg ? (PW'(0) - sel_val) : sel_val;
    end

    always_comb begin
        bcd_adj = bcd_r;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_r[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
        end
        bcd_shift  = {bcd_adj[4*NDIG-2:0], mag_r[PW-1]};
        digits_fmt = bcd_shift;
`ifdef MULT_BCD_BLANK_EN
        begin
            logic lead;
            lead = 1'b1;
            for (int i = NDIG - 1; i >= 1; i--) begin
                if (lead && bcd_shift[4*i +: 4] == 4'd0)
                    digits_fmt[4*i +: 4] = 4'hF;
                else
                    lead = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = MULT;
            MULT:    if (mult_last) state_nxt = ABS;
            ABS:                    state_nxt = CONV;
            CONV:    if (conv_last) state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_r       <= '0;
            b_r       <= '0;
            sel_r     <= '0;
            acc_p     <= '0;
            acc_q     <= '0;
            acc_qm1   <= 1'b0;
            prod_r    <= '0;
            mag_r     <= '0;
            neg_r     <= 1'b0;
            bcd_r     <= '0;
            cnt       <= '0;
            product   <= '0;
            digits    <= '0;
            neg       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_r     <= op_a;
                    b_r     <= op_b;
                    sel_r   <= sel;
                    acc_p   <= '0;
                    acc_q   <= op_b;
                    acc_qm1 <= 1'b0;
                    cnt     <= '0;
                end
                MULT: begin
                    acc_p   <= p_nxt;
                    acc_q   <= q_nxt;
                    acc_qm1 <= acc_q[0];
                    cnt     <= cnt + CW'(1);
                    if (mult_last)
                        prod_r <= {p_nxt[WIDTH-1:0], q_nxt};
                end
                ABS: begin
                    neg_r <= sel_neg;
                    mag_r <= sel_mag;
                    bcd_r <= '0;
                    cnt   <= '0;
                end
                CONV: begin
                    bcd_r <= bcd_shift;
                    mag_r <= {mag_r[PW-2:0], 1'b0};
                    cnt   <= cnt + CW'(1);
                    if (conv_last) begin
                        digits    <= digits_fmt;
                        product   <= prod_r;
                        neg       <= neg_r;
                        out_valid <= 1'b1;
                    end
                end
                HOLD: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_bcd_engine.sv
// tb/tb_mult_bcd_engine.sv - scoreboard bench for mult_bcd_engine (honours MULT_BCD_BLANK_EN)
module tb_mult_bcd_engine;

    localparam int WIDTH = 8;
    localparam int NDIG  = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  op_a = '0;
    logic [7:0]  op_b = '0;
    logic [1:0]  sel = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] product;
    logic [19:0] digits;
    logic        neg;
    logic        busy;

    mult_bcd_engine #(.WIDTH(WIDTH), .NDIG(NDIG)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .sel(sel), .out_valid(out_valid),
        .out_ready(out_ready), .product(product), .digits(digits),
        .neg(neg), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] p;
        logic [19:0] d;
        logic        n;
    } exp_t;

    exp_t sb[$];
    exp_t last;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic push_exp(input int a, input int b, input int s);
        exp_t e;
        logic signed [15:0] v;
        int   mag;
        bit   lead;
        e.p = 16'(a * b);
        v = (s == 1) ? 16'(a) : (s == 2) ? 16'(b) : 16'(a * b);
        e.n = v < 0;
        mag = e.n ? -int'(v) : int'(v);
        for (int i = 0; i < NDIG; i++) begin
            e.d[4*i +: 4] = 4'(mag % 10);
            mag = mag / 10;
        end
`ifdef MULT_BCD_BLANK_EN
        lead = 1'b1;
        for (int i = NDIG - 1; i >= 1; i--) begin
            if (lead && e.d[4*i +: 4] == 4'd0) e.d[4*i +: 4] = 4'hF;
            else lead = 1'b0;
        end
`else
        lead = 1'b0;
`endif
        sb.push_back(e);
    endtask

    task automatic send(input int a, input int b, input int s);
        op_a = 8'(a);
        op_b = 8'(b);
        sel = 2'(s);
        in_valid = 1'b1;
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        push_exp(a, b, s);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result();
        int n;
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'd25);
        if (sb.size() > 0) last = sb.pop_front();
        check("product", 32'(product), 32'(last.p));
        check("digits", 32'(digits), 32'(last.d));
        check("neg", 32'(neg), 32'(last.n));
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("out_valid_after_hs", 32'(out_valid), 32'd0);
        check("in_ready_after_hs", 32'(in_ready), 32'd1);
    endtask

    task automatic txn(input int a, input int b, input int s);
        send(a, b, s);
        wait_result();
        release_out();
    endtask

    initial begin
        #2;
        check("rst_product", 32'(product), 32'd0);
        check("rst_digits", 32'(digits), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        txn(12, -11, 0);
        txn(-128, -128, 0);
        txn(127, -128, 0);
        txn(-7, 3, 1);
        txn(-7, 3, 2);
        txn(0, 55, 0);
        txn(-3, 100, 0);
        txn(-128, 1, 1);

        // consumer stalls while upstream keeps presenting new operands
        out_ready = 1'b0;
        send(-99, 77, 0);
        wait_result();
        for (int i = 0; i < 10; i++) begin
            in_valid = ~in_valid;
            op_a = 8'($urandom_range(0, 255));
            op_b = 8'($urandom_range(0, 255));
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_product", 32'(product), 32'(last.p));
            check("stall_digits", 32'(digits), 32'(last.d));
        end
        in_valid = 1'b0;
        release_out();
        txn(45, 67, 0);

        // reset during MULT step 4 must abort and clear everything
        op_a = 8'd9;
        op_b = 8'(-13);
        sel = 2'b00;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_product", 32'(product), 32'd0);
        check("abort_digits", 32'(digits), 32'd0);
        check("abort_neg", 32'(neg), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        txn(5, 5, 0);

        for (int i = 0; i < 6; i++) begin
            int a, b, s;
            a = int'($urandom_range(0, 255)) - 128;
            b = int'($urandom_range(0, 255)) - 128;
            s = int'($urandom_range(0, 3));
            txn(a, b, s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
